// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO read-side frame sequencer.
package fifo_ctrl_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_FLUSH
    } rd_state_e;

endpackage

// File: rtl/fifo_frame_reader_skid_fifo.sv
// Small register FIFO holding stream words with their last flag.
// Flush empties it in one cycle and takes priority over push/pop.
module skid_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              empty,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W:0]  mem_q [DEPTH];
    logic [DATA_W:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && (cnt_q != '0);
        // a push into a full buffer is only legal when the head leaves this cycle
        do_push  = push && ((cnt_q != OCC_W'(DEPTH)) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = {push_last, push_data};
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];
    assign head_last = mem_q[rd_ptr_q][DATA_W];
    assign empty     = (cnt_q == '0);
    assign occ       = cnt_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains LENGTH words from the sample FIFO read port into a valid/ready stream,
// with a credit-gated skid buffer absorbing the FIFO read latency.
module fifo_frame_reader
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [LEN_W-1:0]  LENGTH,
    input  logic              ABORT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ABORTED,
    output logic [LEN_W-1:0]  WORD_CNT,
    input  logic              FIFO_EMPTY,
    output logic              FIFO_RE,
    input  logic [DATA_W-1:0] FIFO_Q,
    output logic [DATA_W-1:0] M_DATA,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic              M_LAST
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CR_W  = $clog2(BUF_DEPTH + RD_LATENCY + 1);

    rd_state_e             state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic [LEN_W-1:0]      cap_cnt_q, cap_cnt_d;
    logic [LEN_W-1:0]      word_cnt_q, word_cnt_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic [RD_LATENCY-1:0] re_pipe_q, re_pipe_d;

    logic [CR_W-1:0]       inflight;
    logic [OCC_W-1:0]      occ;
    logic                  buf_empty;
    logic                  head_last;
    logic [DATA_W-1:0]     head_data;
    logic                  m_valid;
    logic                  accept;
    logic                  last_accept;
    logic                  fifo_re;
    logic                  capture;
    logic                  push;
    logic                  push_last;
    logic                  flush;

    skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_skid (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .push      (push),
        .push_data (FIFO_Q),
        .push_last (push_last),
        .pop       (accept),
        .flush     (flush),
        .head_data (head_data),
        .head_last (head_last),
        .empty     (buf_empty),
        .occ       (occ)
    );

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CR_W'(re_pipe_q[i]);
        end
        m_valid     = !buf_empty && (state_q != ST_FLUSH);
        accept      = m_valid && M_READY;
        last_accept = accept && head_last;
        // ABORT gates RE in its own cycle so the flush never waits on a new read
        fifo_re     = (state_q == ST_READ) && !FIFO_EMPTY && !ABORT
                      && (issued_q < len_q)
                      && ((inflight + CR_W'(occ)) < CR_W'(BUF_DEPTH));
        capture     = re_pipe_q[RD_LATENCY-1];
        push        = capture && (state_q != ST_FLUSH);
        push_last   = ((cap_cnt_q + LEN_W'(1)) == len_q);
        flush       = (state_q == ST_FLUSH);
        re_pipe_d    = '0;
        re_pipe_d[0] = fifo_re;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            re_pipe_d[i] = re_pipe_q[i-1];
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q + LEN_W'(fifo_re);
        cap_cnt_d  = cap_cnt_q + LEN_W'(capture);
        word_cnt_d = word_cnt_q + LEN_W'(accept);
        done_d     = 1'b0;
        aborted_d  = aborted_q;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    word_cnt_d = '0;
                    if (LENGTH != '0) begin
                        len_d     = LENGTH;
                        issued_d  = '0;
                        cap_cnt_d = '0;
                        state_d   = ST_READ;
                    end else begin
                        done_d    = 1'b1;
                        aborted_d = 1'b0;
                    end
                end
            end
            ST_READ, ST_DRAIN: begin
                if (last_accept) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b0;
                end else if (ABORT) begin
                    state_d = ST_FLUSH;
                end else if ((state_q == ST_READ) && (issued_d == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (inflight == '0) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            cap_cnt_q  <= '0;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            re_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            cap_cnt_q  <= cap_cnt_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            re_pipe_q  <= re_pipe_d;
        end
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = done_q;
    assign ABORTED  = aborted_q;
    assign WORD_CNT = word_cnt_q;
    assign FIFO_RE  = fifo_re;
    assign M_DATA   = head_data;
    assign M_VALID  = m_valid;
    assign M_LAST   = head_last && m_valid;

endmodule
